// File: rtl/sequential_pkg.sv
// Shared helpers for the sequential-logic chapter blocks.
// Elaboration-time sizing checks used by counters and registers.
package sequential_pkg;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // A modulus is legal when 2 <= modulus <= 2**width.
    function automatic bit modulus_ok(input int width, input int modulus);
        return (modulus >= 2) && (clog2(modulus) <= width);
    endfunction

endpackage

// File: rtl/mod_n_counter_if.sv
// Control and status bundle of the modulo-N counter.
// The master drives the controls; the counter is the slave.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    logic             io_clear;
    logic             io_load;
    logic [WIDTH-1:0] io_data;
    logic             io_enable;
    logic             io_up;
    logic [WIDTH-1:0] io_q;
    logic             io_tc;
    logic             io_overflow;

    modport master (
        output io_clear,
        output io_load,
        output io_data,
        output io_enable,
        output io_up,
        input  io_q,
        input  io_tc,
        input  io_overflow
    );

    modport slave (
        input  io_clear,
        input  io_load,
        input  io_data,
        input  io_enable,
        input  io_up,
        output io_q,
        output io_tc,
        output io_overflow
    );
endinterface

// File: rtl/enable_reset_ff.sv
// Single flip-flop cell with enable and synchronous clear.
// Clear only acts when the cell is enabled.
module enable_reset_ff (
    input  logic clock,
    input  logic reset,
    input  logic io_enable,
    input  logic io_clear,
    input  logic io_d,
    output logic io_q
);
    // Async reset; enabled edges take clear or data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_q <= 1'b0;
        end else if (io_enable) begin
            io_q <= io_clear ? 1'b0 : io_d;
        end
    end
endmodule

// File: rtl/enable_reset_register.sv
// Bank of enable/clear flip-flop cells sharing clock and reset.
// Forms the state register of multi-bit sequential blocks.
module enable_reset_register #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enable,
    input  logic             io_clear,
    input  logic [WIDTH-1:0] io_data,
    output logic [WIDTH-1:0] io_q
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        enable_reset_ff u_ff (
            .clock     (clock),
            .reset     (reset),
            .io_enable (io_enable),
            .io_clear  (io_clear),
            .io_d      (io_data[i]),
            .io_q      (io_q[i])
        );
    end
endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with load, clear, terminal count
// and a sticky wrap flag, built on an enable/clear register bank.
module mod_n_counter
    import sequential_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic           clock,
    input  logic           reset,
    mod_n_counter_if.slave bus
);
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH:0]   MOD  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   LAST = MOD - 1'b1;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic [WIDTH:0]   data_ext;
    logic             at_top;
    logic             at_zero;
    logic             sel_clear;
    logic             sel_load;
    logic             sel_up;
    logic             sel_down;
    logic             sel_hold;
    logic             wrap;
    logic             reg_en;
    logic             ovf_q;

    // Wide arithmetic: carry-out of +1 at MODULUS, borrow of -1 at 0.
    assign q_ext    = {1'b0, q};
    assign inc_ext  = q_ext + 1'b1;
    assign dec_ext  = q_ext - 1'b1;
    assign data_ext = {1'b0, bus.io_data};
    assign at_top   = (inc_ext == MOD);
    assign at_zero  = dec_ext[WIDTH];

    // One-hot selects encoding clear > load > count > hold.
    assign sel_clear = bus.io_clear;
    assign sel_load  = !bus.io_clear && bus.io_load;
    assign sel_up    = !bus.io_clear && !bus.io_load
                       && bus.io_enable && bus.io_up;
    assign sel_down  = !bus.io_clear && !bus.io_load
                       && bus.io_enable && !bus.io_up;
    assign sel_hold  = !(sel_clear || sel_load || sel_up || sel_down);

    // Next-state mux feeding the register data inputs.
    always_comb begin
        d    = q;
        wrap = 1'b0;
        unique case (1'b1)
            sel_clear: d = '0;
            sel_load: begin
                if (data_ext < MOD) d = bus.io_data;
                else                d = LAST[WIDTH-1:0];
            end
            sel_up: begin
                if (at_top) begin
                    d    = '0;
                    wrap = 1'b1;
                end else begin
                    d = inc_ext[WIDTH-1:0];
                end
            end
            sel_down: begin
                if (at_zero) begin
                    d    = LAST[WIDTH-1:0];
                    wrap = 1'b1;
                end else begin
                    d = dec_ext[WIDTH-1:0];
                end
            end
            sel_hold: d = q;
            default:  d = q;
        endcase
    end

    assign reg_en = bus.io_clear | bus.io_load | bus.io_enable;

    enable_reset_register #(
        .WIDTH (WIDTH)
    ) u_state (
        .clock     (clock),
        .reset     (reset),
        .io_enable (reg_en),
        .io_clear  (bus.io_clear),
        .io_data   (d),
        .io_q      (q)
    );

    // Sticky wrap flag; only reset or clear drop it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (bus.io_clear) begin
            ovf_q <= 1'b0;
        end else if (wrap) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.io_q        = q;
    assign bus.io_overflow = ovf_q;
    assign bus.io_tc       = bus.io_enable
                             & (bus.io_up ? at_top : at_zero);
endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: a decimal (4b, mod 10)
// instance and a full-range (3b, mod 8) instance.
module tb_mod_n_counter;
    logic clock;
    logic reset;

    mod_n_counter_if #(.WIDTH(4)) bus_a ();
    mod_n_counter_if #(.WIDTH(3)) bus_b ();

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    mod_n_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int    dut;
        string name;
        int    q;
        int    tc;
        int    ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event tick_ev;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: pops expectations after each edge or explicit tick.
    initial begin
        exp_t e;
        int aq, atc, aov;
        forever begin
            @(posedge clock or tick_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    aq  = int'(bus_a.io_q);
                    atc = int'(bus_a.io_tc);
                    aov = int'(bus_a.io_overflow);
                end else begin
                    aq  = int'(bus_b.io_q);
                    atc = int'(bus_b.io_tc);
                    aov = int'(bus_b.io_overflow);
                end
                n_tests++;
                if (aq != e.q || atc != e.tc || aov != e.ovf) begin
                    n_fail++;
                    $display("FAIL %s: got q=%0d tc=%0d ovf=%0d, expected q=%0d tc=%0d ovf=%0d",
                             e.name, aq, atc, aov, e.q, e.tc, e.ovf);
                end
            end
        end
    end

    task automatic push(input int dut, input int q, input int tc,
                        input int ovf, input string nm);
        exp_t e;
        e.dut  = dut;
        e.name = nm;
        e.q    = q;
        e.tc   = tc;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic drive(input int dut, input logic clr, input logic ld,
                         input int data, input logic en, input logic up);
        if (dut == 0) begin
            bus_a.io_clear  = clr;
            bus_a.io_load   = ld;
            bus_a.io_data   = 4'(data);
            bus_a.io_enable = en;
            bus_a.io_up     = up;
        end else begin
            bus_b.io_clear  = clr;
            bus_b.io_load   = ld;
            bus_b.io_data   = 3'(data);
            bus_b.io_enable = en;
            bus_b.io_up     = up;
        end
    endtask

    // One clocked vector with its hand-computed post-edge result.
    task automatic step(input int dut, input logic clr, input logic ld,
                        input int data, input logic en, input logic up,
                        input int eq, input int etc, input int eo,
                        input string nm);
        @(negedge clock);
        drive(dut, clr, ld, data, en, up);
        push(dut, eq, etc, eo, nm);
        @(posedge clock);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #3;
        push(0, 0, 0, 0, "reset_a");
        push(1, 0, 0, 0, "reset_b");
        ->tick_ev;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 1; i <= 10; i++)
            step(0, 0, 0, 0, 1, 1, i % 10, (i == 9) ? 1 : 0,
                 (i == 10) ? 1 : 0, "up_wrap");
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, "ovf_sticky");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "clear");
        step(0, 0, 1, 2, 0, 0, 2, 0, 0, "load2");
        step(0, 0, 0, 0, 1, 0, 1, 0, 0, "down_1");
        step(0, 0, 0, 0, 1, 0, 0, 1, 0, "down_0_tc");
        step(0, 0, 0, 0, 1, 0, 9, 0, 1, "down_wrap");
        step(0, 0, 1, 13, 0, 0, 9, 0, 1, "load_clamp13");
        step(0, 0, 1, 4, 1, 1, 4, 0, 1, "load_beats_count");
        step(0, 0, 1, 10, 0, 0, 9, 0, 1, "load_clamp10");
        step(0, 1, 1, 5, 1, 1, 0, 0, 0, "clear_priority");
        step(0, 0, 1, 9, 0, 0, 9, 0, 0, "load9");
        step(0, 0, 1, 3, 1, 1, 3, 0, 0, "load_during_tc");
        step(0, 0, 0, 0, 0, 1, 3, 0, 0, "hold");
        step(0, 0, 0, 0, 1, 0, 2, 0, 0, "dir_down");
        step(0, 0, 0, 0, 1, 1, 3, 0, 0, "dir_up");
        step(0, 0, 1, 9, 0, 0, 9, 0, 0, "load9_again");
        step(0, 0, 0, 0, 1, 1, 0, 0, 1, "wrap_again");
        step(0, 0, 1, 7, 0, 0, 7, 0, 1, "load7");

        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        push(0, 0, 0, 0, "async_reset");
        ->tick_ev;
        @(negedge clock);
        reset = 1'b1;
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, "first_after_reset");
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);

        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "b_clear");
        for (int i = 1; i <= 8; i++)
            step(1, 0, 0, 0, 1, 1, i % 8, (i == 7) ? 1 : 0,
                 (i == 8) ? 1 : 0, "b_full_wrap");
        step(1, 0, 1, 7, 0, 0, 7, 0, 1, "b_load7_noclamp");

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clock);
        #2;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run time exceeded, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
